alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
//  Sits between a single requester and TotalALU and sequences one ALU operation at a time.
//  Single-cycle functs (AND/OR/ADD/SUB/SLT/SRL) take one issue cycle.
//  MULTU is held for MUL_CYCLES cycles, then read back as MFHI then MFLO.
//  The result returns on a valid/ready response channel as {rsp_hi, rsp_lo}.
// PARAMETERS
//  MUL_CYCLES  32     cycles Signal=25 is held with stable operands before Hi/Lo read
//  NOP_FUNCT   6'd0   Signal driven to ALU when not issuing (unimplemented funct, output ignored)
// PORTS
//  clk         in   1   single clock, rising edge
//  reset       in   1   asynchronous, active-high
//  req_valid   in   1   request present
//  req_ready   out  1   controller can accept (high only in IDLE)
//  req_funct   in   6   36 AND, 37 OR, 32 ADD, 34 SUB, 42 SLT, 2 SRL, 25 MULTU, 27 DIVU
//  req_a       in   32  operand A
//  req_b       in   32  operand B
//  rsp_valid   out  1   response held until accepted
//  rsp_ready   in   1   consumer accepts response
//  rsp_lo      out  32  result (single-cycle op) or Lo (MULTU/DIVU)
//  rsp_hi      out  32  Hi (MULTU/DIVU), 0 otherwise
//  rsp_err     out  1   funct not supported; rsp_lo=rsp_hi=0
//  alu_signal  out  6   to TotalALU.Signal
//  alu_dataA   out  32  to TotalALU.dataA
//  alu_dataB   out  32  to TotalALU.dataB
//  alu_out     in   32  from TotalALU.Output
// BEHAVIOUR
//  Reset (async): state=IDLE; req_ready=1; rsp_valid=0; rsp_lo=rsp_hi=0; rsp_err=0;
//   alu_signal=NOP_FUNCT; alu_dataA=alu_dataB=0; wait counter=0.
//  Accept = req_valid&&req_ready at an edge: latch funct/a/b into alu_* regs.
//  Next state: ISSUE for single-cycle functs; MUL_WAIT for 25; RESP with rsp_err=1 for illegal functs.
//  FSM IDLE -> ISSUE | MUL_WAIT | RESP
//   ISSUE:    alu_signal=funct for one cycle; at the closing edge rsp_lo<=alu_out, rsp_hi<=0 -> RESP.
//   MUL_WAIT: alu_signal=25, operands frozen, counter 0..MUL_CYCLES-1.
//             At count MUL_CYCLES-1, set alu_signal=16 -> READ_HI.
//   READ_HI:  alu_signal=16; at the edge rsp_hi<=alu_out; alu_signal<=18 -> READ_LO.
//   READ_LO:  alu_signal=18; at the edge rsp_lo<=alu_out -> RESP.
//   RESP:     rsp_valid=1, alu_signal=NOP_FUNCT.
//             rsp_valid&&rsp_ready -> IDLE: rsp_valid=0, rsp_err=0, req_ready=1.
//  Latency, accept edge to rsp_valid rising: single-cycle 2 edges; MULTU MUL_CYCLES+3 edges; illegal 1 edge.
//  Throughput: at most one op outstanding; req_ready=0 outside IDLE.
//   A request held during busy states is not consumed.
//  Backpressure: rsp_lo/rsp_hi/rsp_err stable while rsp_valid=1 and rsp_ready=0.
//  Operands and alu_signal change only at state transitions, never mid-multiply.
//  Counter is 6 bits, saturating-free; it clears on entry to MUL_WAIT.
//  Reset mid-operation (any state): immediate return to reset values.
//   The partial result is discarded and no rsp_valid pulse is produced.
//  SRL: operand B carries the shift amount as given; the controller does no width masking.
// CONFIGURATION
//  SEQ_DIVU_EN defined: funct 27 is sequenced exactly like MULTU.
//   Hold 27 for MUL_CYCLES cycles, then read 16 -> rsp_hi (remainder), then 18 -> rsp_lo (quotient).
//  SEQ_DIVU_EN undefined: funct 27 is illegal -> RESP with rsp_err=1, ALU never driven with 27.
// TESTING
//  ADD a=5 b=7 -> rsp_valid 2 edges after accept.
//   rsp_lo=12, rsp_hi=0, rsp_err=0; alu_signal=32 for exactly 1 cycle.
//  SUB a=3 b=5 -> rsp_lo=32'hFFFFFFFE; SLT a=3 b=5 -> rsp_lo=1.
//  MULTU a=32'hFFFFFFFF b=2 -> alu_signal=25 for 32 cycles, then 16, then 18 for 1 cycle each.
//   rsp_hi=1, rsp_lo=32'hFFFFFFFE; rsp_valid 35 edges after accept.
//  funct=27, macro off -> rsp_err=1, rsp_lo=rsp_hi=0 after 1 edge.
//   Macro on, a=100 b=7 -> rsp_lo=14, rsp_hi=2.
//  Backpressure: hold rsp_ready=0 for 5 cycles after ADD 1+1.
//   rsp_valid stays high, rsp_lo=2 stable, req_ready=0; IDLE one edge after rsp_ready=1.
//  Assert reset at MUL_WAIT count 10 -> all outputs at reset values immediately.
//   Next ADD 1+2 after release returns rsp_lo=3.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one TotalALU operation at a time on behalf of a
// single requester and returns {rsp_hi, rsp_lo} on a valid/ready channel.
// Single-cycle functs run for one ISSUE cycle; MULTU is held for MUL_CYCLES
// cycles and then read back through MFHI (16) and MFLO (18).
// Optional feature macro: SEQ_DIVU_EN -- when defined, DIVU (27) is sequenced
// exactly like MULTU; otherwise 27 is rejected with rsp_err.
module alu_op_sequencer #(
  parameter int unsigned MUL_CYCLES = 32,
  parameter logic [5:0]  NOP_FUNCT  = 6'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_lo,
  output logic [31:0] rsp_hi,
  output logic        rsp_err,
  output logic [5:0]  alu_signal,
  output logic [31:0] alu_dataA,
  output logic [31:0] alu_dataB,
  input  logic [31:0] alu_out
);

  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_MULTU = 6'd25;
`ifdef SEQ_DIVU_EN
  localparam logic [5:0] F_DIVU  = 6'd27;
`endif
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] CNT_LAST = 6'(MUL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_MUL_WAIT, S_READ_HI, S_READ_LO, S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  sig_q, sig_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] lo_q, lo_d, hi_q, hi_d;
  logic        err_q, err_d;
  logic        is_single, is_long;

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_lo     = lo_q;
  assign rsp_hi     = hi_q;
  assign rsp_err    = err_q;
  assign alu_signal = sig_q;
  assign alu_dataA  = a_q;
  assign alu_dataB  = b_q;

  // Classify the incoming funct: one-cycle op, long Hi/Lo op, or illegal.
  always_comb begin
    is_single = 1'b0;
    is_long   = 1'b0;
    case (req_funct)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL: is_single = 1'b1;
      F_MULTU: is_long = 1'b1;
`ifdef SEQ_DIVU_EN
      F_DIVU:  is_long = 1'b1;
`endif
      default: ;
    endcase
  end

  // Next-state and registered-output logic; ALU drive only moves on transitions.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          a_d = req_a;
          b_d = req_b;
          if (is_single) begin
            sig_d   = req_funct;
            state_d = S_ISSUE;
          end else if (is_long) begin
            sig_d   = req_funct;
            cnt_d   = 6'd0;
            state_d = S_MUL_WAIT;
          end else begin
            // Illegal funct never reaches the ALU; answer straight away.
            err_d   = 1'b1;
            lo_d    = 32'd0;
            hi_d    = 32'd0;
            state_d = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        lo_d    = alu_out;
        hi_d    = 32'd0;
        sig_d   = NOP_FUNCT;
        state_d = S_RESP;
      end
      S_MUL_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          sig_d   = F_MFHI;
          state_d = S_READ_HI;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_READ_HI: begin
        hi_d    = alu_out;
        sig_d   = F_MFLO;
        state_d = S_READ_LO;
      end
      S_READ_LO: begin
        lo_d    = alu_out;
        sig_d   = NOP_FUNCT;
        state_d = S_RESP;
      end
      S_RESP: begin
        // Payload stays put under backpressure; only err clears on handshake.
        if (rsp_ready) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sig_q   <= NOP_FUNCT;
      cnt_q   <= 6'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      lo_q    <= 32'd0;
      hi_q    <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
    end
  end

endmodule
